// File: rtl/frame_reader.sv
// Streams a frame buffer out as pixel packets with sop/eop tags.
// A credit-checked read pipeline feeds a small FIFO that absorbs downstream back-pressure.
module frame_reader #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int DW     = 12,
    parameter int AW     = 17,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [AW-1:0] rdaddress,
    input  logic [DW-1:0] rddata,
    output logic [DW-1:0] data_out,
    output logic          sop_out,
    output logic          eop_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic          frame_done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int PW = $clog2(FIFO_D);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          in_flight_q, in_flight_d;
    logic          sop_tag_q, sop_tag_d;
    logic          eop_tag_q, eop_tag_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [DW+1:0] fifo_mem_q [FIFO_D];

    logic          empty_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic [PW+1:0] credit_s;
    logic [DW+1:0] head_s;

    assign empty_s  = (count_q == '0);
    // Space must exist for everything already buffered or in flight plus this read.
    assign credit_s = {1'b0, count_q} + {{(PW + 1){1'b0}}, in_flight_q} + (PW + 2)'(1);
    assign issue_s  = (state_q == ST_RUN) && (credit_s <= (PW + 2)'(FIFO_D));
    assign push_s   = in_flight_q;
    assign pop_s    = !empty_s && ready_in;
    assign head_s   = fifo_mem_q[rd_ptr_q];

    // Frame sequencing state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (issue_s && (addr_q == LAST_ADDR) && !enable) state_d = ST_DRAIN;
                else                                              state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (empty_s && !in_flight_q) state_d = ST_IDLE;
                else                         state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read address counter and in-flight tag capture.
    always_comb begin
        addr_d      = addr_q;
        in_flight_d = issue_s;
        sop_tag_d   = sop_tag_q;
        eop_tag_d   = eop_tag_q;
        if (issue_s) begin
            sop_tag_d = (addr_q == '0);
            eop_tag_d = (addr_q == LAST_ADDR);
            if (addr_q == LAST_ADDR) addr_d = '0;
            else                     addr_d = addr_q + AW'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            in_flight_q <= 1'b0;
            sop_tag_q   <= 1'b0;
            eop_tag_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            in_flight_q <= in_flight_d;
            sop_tag_q   <= sop_tag_d;
            eop_tag_q   <= eop_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are never observed while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_q[wr_ptr_q] <= {sop_tag_q, eop_tag_q, rddata};
    end

    assign rdaddress  = addr_q;
    assign valid_out  = !empty_s;
    assign data_out   = empty_s ? '0   : head_s[DW-1:0];
    assign sop_out    = empty_s ? 1'b0 : head_s[DW+1];
    assign eop_out    = empty_s ? 1'b0 : head_s[DW];
    assign frame_done = pop_s && head_s[DW];

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a 64x32 instance for the main scenarios and a 4x2 instance
// for back-to-back tiny frames, both checked against a pixel-stream model.
module tb_frame_reader;

    localparam int NA = 64 * 32;
    localparam int NB = 4 * 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ready = 1'b0;
    logic [11:0] rdaddress, rddata, data_out;
    logic        sop, eop, valid, fdone;

    logic        en_b = 1'b0, ready_b = 1'b0;
    logic [2:0]  rdaddress_b;
    logic [11:0] rddata_b, data_b;
    logic        sop_b, eop_b, valid_b, fdone_b;

    int vectors = 0, miscompares = 0;

    int          exp_a = 0, pending_a = 0, frames_a = 0;
    logic [11:0] prev_addr_a = 12'd0;
    bit          prev_xfer_a = 1'b0;
    int          exp_b = 0, xfer_b = 0, eops_b = 0;
    bit          b_started = 1'b0;

    always #5 clk = ~clk;

    frame_reader #(.IMG_W(64), .IMG_H(32), .DW(12), .AW(12), .FIFO_D(4)) dut_a (
        .clk(clk), .reset(rst), .enable(en), .rdaddress(rdaddress), .rddata(rddata),
        .data_out(data_out), .sop_out(sop), .eop_out(eop), .valid_out(valid),
        .ready_in(ready), .frame_done(fdone));

    frame_reader #(.IMG_W(4), .IMG_H(2), .DW(12), .AW(3), .FIFO_D(4)) dut_b (
        .clk(clk), .reset(rst), .enable(en_b), .rdaddress(rdaddress_b), .rddata(rddata_b),
        .data_out(data_b), .sop_out(sop_b), .eop_out(eop_b), .valid_out(valid_b),
        .ready_in(ready_b), .frame_done(fdone_b));

    // Frame buffers whose content is the low address bits, one-cycle read latency.
    always @(posedge clk) begin
        rddata   <= rdaddress;
        rddata_b <= {9'd0, rdaddress_b};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: every transfer must be the next pixel index of the frame sequence.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_a", 32'({valid, sop, eop, fdone, data_out, rdaddress}), 32'd0);
            chk("rst_out_b", 32'({valid_b, sop_b, eop_b, fdone_b, data_b, rdaddress_b}), 32'd0);
            exp_a = 0; pending_a = 0; prev_addr_a = 12'd0; prev_xfer_a = 1'b0;
            exp_b = 0; b_started = 1'b0;
        end else begin
            pending_a = pending_a + int'(rdaddress != prev_addr_a) - int'(prev_xfer_a);
            chk("occupancy_a", 32'(pending_a <= 4), 32'd1);
            if (valid) begin
                chk("data_a", 32'(data_out), 32'(exp_a));
                chk("sop_a", 32'(sop), 32'(exp_a == 0));
                chk("eop_a", 32'(eop), 32'(exp_a == NA - 1));
            end
            chk("frame_done_a", 32'(fdone), 32'(valid && ready && exp_a == NA - 1));
            prev_xfer_a = valid && ready;
            prev_addr_a = rdaddress;
            if (valid && ready) begin
                if (exp_a == NA - 1) frames_a++;
                exp_a = (exp_a + 1) % NA;
            end

            if (b_started) chk("gapless_b", 32'(valid_b), 32'd1);
            if (valid_b) begin
                chk("data_b", 32'(data_b), 32'(exp_b));
                chk("sop_b", 32'(sop_b), 32'(exp_b == 0));
                chk("eop_b", 32'(eop_b), 32'(exp_b == NB - 1));
                b_started = 1'b1;
            end
            chk("frame_done_b", 32'(fdone_b), 32'(valid_b && ready_b && exp_b == NB - 1));
            if (valid_b && ready_b) begin
                xfer_b++;
                if (exp_b == NB - 1) eops_b++;
                exp_b = (exp_b + 1) % NB;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_head(input int px, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            step();
            if (valid && data_out == 12'(px)) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_frames(input int target, input bit rand_ready, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            step();
            if (frames_a >= target) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b1; ready = 1'b1; en_b = 1'b1; ready_b = 1'b1;

        // First issue lands on data_out two cycles later, tagged sop.
        next_neg();
        chk("lat_c0", 32'({valid, rdaddress}), 32'({1'b0, 12'd0}));
        next_neg();
        chk("lat_c1", 32'({valid, rdaddress}), 32'({1'b0, 12'd1}));
        next_neg();
        chk("lat_c2", 32'({valid, sop, data_out}), 32'({1'b1, 1'b1, 12'h000}));

        // One pixel per cycle once the pipeline is primed.
        for (int i = 0; i < 200; i++) begin
            next_neg();
            chk("throughput_a", 32'(valid), 32'd1);
        end

        // Long stall at pixel 1000: head holds, reads stop at four outstanding.
        step();
        wait_head(1000, "reach_1000");
        ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("stall_hold", 32'({valid, data_out}), 32'({1'b1, 12'h3E8}));
        end
        chk("stall_addr", 32'(rdaddress), 32'd1004);
        ready = 1'b1;
        step();
        chk("resume", 32'(data_out), 32'h3E9);

        // Two full frames under random back-pressure.
        f0 = frames_a;
        wait_frames(f0 + 1, 1'b0, "finish_frame0");
        wait_frames(f0 + 3, 1'b1, "random_2frames");
        chk("frames_random", 32'(frames_a - f0), 32'd3);
        ready = 1'b1;

        // Drop enable mid-frame: frame completes, then stream stops at address 0.
        wait_head(500, "reach_500");
        en = 1'b0;
        f0 = frames_a;
        wait_frames(f0 + 1, 1'b0, "drain_to_eop");
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_after_drain", 32'({valid, rdaddress}), 32'd0);
        end
        en = 1'b1;
        wait_head(0, "restart_frame");
        chk("restart_sop", 32'(sop), 32'd1);

        // Reset mid-frame: outputs clear at once and the next frame starts at pixel 0.
        wait_head(1500, "reach_1500");
        rst = 1'b1;
        #1;
        chk("async_rst", 32'({valid, sop, eop, fdone, data_out, rdaddress}), 32'd0);
        step();
        step();
        rst = 1'b0;
        wait_head(0, "post_rst_frame");
        chk("post_rst_sop", 32'({sop, data_out}), 32'({1'b1, 12'h000}));
        repeat (50) step();

        chk("eop_every_8th_b", 32'(eops_b), 32'(xfer_b / NB));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter IMG_W, default 320, meaning pixels per line.
REQ-002 Parameter IMG_H, default 240, meaning lines per frame; frame size N = IMG_W*IMG_H = 76800.
REQ-003 Parameter DW, default 12, meaning pixel width (RGB444).
REQ-004 Parameter AW, default 17, meaning frame-buffer address width.
REQ-005 Parameter FIFO_D, default 4, meaning output FIFO depth (power of 2, >= 3).
REQ-006 clk  in  1  pixel clock (VGA-domain 25 MHz); all logic rising-edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  level; while high, frames are streamed back-to-back.
REQ-009 rdaddress  out  AW  frame-buffer read address.
REQ-010 rddata  in  DW  frame-buffer read data, valid exactly 1 cycle after rdaddress.
REQ-011 data_out  out  DW  pixel to filter stage.
REQ-012 sop_out  out  1  high with pixel 0 of a frame.
REQ-013 eop_out  out  1  high with pixel N-1 of a frame.
REQ-014 valid_out  out  1  data_out/sop_out/eop_out qualified.
REQ-015 ready_in  in  1  downstream back-pressure; transfer when valid_out && ready_in.
REQ-016 frame_done  out  1  one-cycle pulse on the transfer of the eop pixel.

Function
REQ-017 States: IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when address N-1 issued and enable=0; DRAIN->IDLE when FIFO empty and no read in flight.
REQ-018 In RUN, wrapping from address N-1 to 0 with enable=1 stays in RUN with no gap cycle.
REQ-019 A read is issued (address counter advances) in a cycle only if state=RUN and occupancy + in_flight + 1 <= FIFO_D (credit rule), guaranteeing no FIFO overflow regardless of ready_in.
REQ-020 in_flight is 1 in the cycle after an issue, else 0; returning rddata is pushed with sop tag (addr==0) and eop tag (addr==N-1) captured at issue.
REQ-021 Address counter counts 0..N-1, wraps to 0; rdaddress holds its value when no issue occurs.
REQ-022 Latency: address issued in cycle c appears on data_out with valid_out=1 in cycle c+2 if FIFO was empty.
REQ-023 valid_out = FIFO non-empty; outputs are driven from FIFO head; head held stable while valid_out && !ready_in.
REQ-024 Simultaneous push and pop on a full or empty FIFO are both legal; occupancy unchanged when both occur.
REQ-025 ready_in held low for any duration loses no pixel and duplicates no pixel.
REQ-026 enable deasserted mid-frame: current frame completes through eop, then IDLE; no partial frames emitted.
REQ-027 Sustained throughput with ready_in=1: one pixel per cycle after initial latency.

Reset
REQ-028 On reset assertion (any cycle, asynchronously): state=IDLE, address=0, FIFO emptied, in_flight=0, valid_out=0, sop_out=0, eop_out=0, frame_done=0, data_out=0, rdaddress=0.
REQ-029 Reset mid-frame discards all buffered and in-flight pixels; next frame after release starts at address 0 with sop.

Verification
REQ-030 reset release, enable=1, ready_in=1, buffer model q=addr[11:0] -> first valid_out 2 cycles after first issue, data 0x000 with sop_out=1; pixel 76799 with eop_out=1 and frame_done pulse; next cycle pixel 0 with sop_out=1.
REQ-031 ready_in random 50% for 2 full frames -> received sequence 0..76799 twice in order, exactly one sop and one eop per frame, FIFO occupancy never > FIFO_D.
REQ-032 ready_in=0 for 100 cycles at pixel 1000 -> data_out holds 1000 (0x3E8) all 100 cycles; issues stop after occupancy reaches FIFO_D; stream resumes 1000,1001,...
REQ-033 enable dropped at pixel 500 -> stream continues to pixel 76799 with eop, then valid_out=0 and state IDLE; re-raise enable -> new frame from address 0.
REQ-034 reset pulsed at pixel 30000 with ready_in=1 -> all outputs 0 within the reset cycle; after release, next output pixel 0 with sop_out=1, no pixel 30000+ emitted.
REQ-035 IMG_W=4, IMG_H=2 with ready_in=1 -> eop on every 8th transfer, no gap between frames.
